shim_ads816x_adc_timing_calc_multi: RTL and testbench

Runtime-configurable successor of the ADS816x nCS timing calculator. It computes the minimum nCS-high time in SPI clock cycles for any ADS816x model, selected at run time, from the SPI clock frequency. A single shared restoring divider gives fixed, deterministic latency. It sits between the SPI clock configuration logic and the ADC SPI core, which consumes n_cs_high_time once done is high.

---
 rtl/shim_ads816x_adc_timing_calc_multi.sv | 203 ++++++++++++++++++++
 tb/tb_shim_ads816x_adc_timing_calc_multi.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shim_ads816x_adc_timing_calc_multi.sv
// Minimum nCS-high time (SPI cycles) for a run-time selected ADS816x model; shared restoring divider.
// Fixed latency: done rises 132 edges after calc is sampled in IDLE; calc is a level request, held high to keep the result.
module shim_ads816x_adc_timing_calc_multi #(
    parameter int CMD_BITS        = 16,
    parameter int MIN_CONV_CYCLES = 3,
    parameter int OUT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          spi_clk_freq_hz,
    input  logic [1:0]           model_sel,
    input  logic                 calc,
    output logic [OUT_WIDTH-1:0] n_cs_high_time,
    output logic [15:0]          t_conv_cycles,
    output logic                 done,
    output logic                 busy,
    output logic                 saturated,
    output logic                 lock_viol
);

    typedef enum logic [2:0] {
        IDLE,
        DIV_CONV,
        DIV_CYCLE,
        RESULT,
        DONE
    } state_t;

    localparam logic [31:0] DIVISOR  = 32'd1_000_000_000;
    localparam logic [63:0] ROUND_UP = 64'd999_999_999;
    localparam logic [31:0] CMD_W    = 32'(CMD_BITS);
    localparam logic [31:0] MIN_W    = 32'(MIN_CONV_CYCLES);
    localparam logic [31:0] OUT_MAX  = (32'd1 << OUT_WIDTH) - 32'd1;
    localparam logic [6:0]  LAST_IT  = 7'd64;

    state_t         state_q, state_d;
    logic [31:0]    freq_q;
    logic [1:0]     model_q;
    logic [63:0]    dvd_q;
    logic [31:0]    rem_q;
    logic [31:0]    quo_q;
    logic [6:0]     cnt_q;
    logic [31:0]    conv_q;
    logic [31:0]    cyc_q;
    logic [31:0]    res_q;

    logic           changed;
    logic           start, abort_lock, abort_calc;
    logic           div_step, fin_conv, fin_cyc, do_result, do_done;
    logic [32:0]    rem_sh, rem_sub;
    logic           q_bit;
    logic [31:0]    rem_nx;

    // ADS8166 timing doubles as the reserved encoding.
    function automatic logic [11:0] t_ns(input logic [1:0] m, input logic use_cycle);
        case (m)
            2'd1:    t_ns = use_cycle ? 12'd2000 : 12'd1200;
            2'd2:    t_ns = use_cycle ? 12'd1000 : 12'd660;
            default: t_ns = use_cycle ? 12'd4000 : 12'd2500;
        endcase
    endfunction

    function automatic logic [63:0] load_dvd(input logic [31:0] f, input logic [1:0] m,
                                             input logic use_cycle);
        load_dvd = ({32'd0, f} * {52'd0, t_ns(m, use_cycle)}) + ROUND_UP;
    endfunction

    // Restoring step: the borrow of the trial subtraction selects the quotient bit.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[63]};
        rem_sub = rem_sh - {1'b0, DIVISOR};
        q_bit   = ~rem_sub[32];
        rem_nx  = q_bit ? rem_sub[31:0] : rem_sh[31:0];
    end

    assign changed = (spi_clk_freq_hz != freq_q) || (model_sel != model_q);
    assign busy    = (state_q == DIV_CONV) || (state_q == DIV_CYCLE) || (state_q == RESULT);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        abort_lock = 1'b0;
        abort_calc = 1'b0;
        div_step   = 1'b0;
        fin_conv   = 1'b0;
        fin_cyc    = 1'b0;
        do_result  = 1'b0;
        do_done    = 1'b0;
        if (state_q == IDLE) begin
            if (calc) begin
                start   = 1'b1;
                state_d = DIV_CONV;
            end
        end else if (changed) begin
            abort_lock = 1'b1;
            state_d    = IDLE;
        end else if (!calc) begin
            abort_calc = 1'b1;
            state_d    = IDLE;
        end else begin
            case (state_q)
                DIV_CONV: begin
                    if (cnt_q == LAST_IT) begin
                        fin_conv = 1'b1;
                        state_d  = DIV_CYCLE;
                    end else begin
                        div_step = 1'b1;
                    end
                end
                DIV_CYCLE: begin
                    if (cnt_q == LAST_IT) begin
                        fin_cyc = 1'b1;
                        state_d = RESULT;
                    end else begin
                        div_step = 1'b1;
                    end
                end
                RESULT: begin
                    do_result = 1'b1;
                    state_d   = DONE;
                end
                DONE: begin
                    do_done = ~done;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            freq_q         <= '0;
            model_q        <= '0;
            dvd_q          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            cnt_q          <= '0;
            conv_q         <= '0;
            cyc_q          <= '0;
            res_q          <= '0;
            n_cs_high_time <= '0;
            t_conv_cycles  <= '0;
            done           <= 1'b0;
            saturated      <= 1'b0;
            lock_viol      <= 1'b0;
        end else begin
            if (start) begin
                freq_q    <= spi_clk_freq_hz;
                model_q   <= model_sel;
                lock_viol <= 1'b0;
                saturated <= 1'b0;
                done      <= 1'b0;
                dvd_q     <= load_dvd(spi_clk_freq_hz, model_sel, 1'b0);
                rem_q     <= '0;
                quo_q     <= '0;
                cnt_q     <= '0;
            end
            if (div_step) begin
                dvd_q <= {dvd_q[62:0], 1'b0};
                rem_q <= rem_nx;
                quo_q <= {quo_q[30:0], q_bit};
                cnt_q <= cnt_q + 7'd1;
            end
            if (fin_conv) begin
                conv_q <= (quo_q > MIN_W) ? quo_q : MIN_W;
                dvd_q  <= load_dvd(freq_q, model_q, 1'b1);
                rem_q  <= '0;
                quo_q  <= '0;
                cnt_q  <= '0;
            end
            if (fin_cyc) begin
                cyc_q <= (quo_q > CMD_W) ? (quo_q - CMD_W) : 32'd0;
            end
            if (do_result) begin
                res_q <= (conv_q > cyc_q) ? conv_q : cyc_q;
            end
            if (do_done) begin
                n_cs_high_time <= (res_q > OUT_MAX) ? OUT_MAX[OUT_WIDTH-1:0] : res_q[OUT_WIDTH-1:0];
                saturated      <= (res_q > OUT_MAX);
                t_conv_cycles  <= (conv_q > 32'd65535) ? 16'hFFFF : conv_q[15:0];
                done           <= 1'b1;
            end
            if (abort_lock) begin
                lock_viol <= 1'b1;
                done      <= 1'b0;
            end
            if (abort_calc) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shim_ads816x_adc_timing_calc_multi.sv
// Bench for the ADS816x nCS-high timing calculator: timing-level reference model plus directed vectors.
module tb_shim_ads816x_adc_timing_calc_multi;

    logic        clk;
    logic        resetn;
    logic [31:0] spi_clk_freq_hz;
    logic [1:0]  model_sel;
    logic        calc;
    logic [7:0]  n_cs_high_time;
    logic [15:0] t_conv_cycles;
    logic        done, busy, saturated, lock_viol;

    int n_checks = 0;
    int n_errs   = 0;

    shim_ads816x_adc_timing_calc_multi #(
        .CMD_BITS(16), .MIN_CONV_CYCLES(3), .OUT_WIDTH(8)
    ) dut (
        .clk(clk), .resetn(resetn), .spi_clk_freq_hz(spi_clk_freq_hz),
        .model_sel(model_sel), .calc(calc), .n_cs_high_time(n_cs_high_time),
        .t_conv_cycles(t_conv_cycles), .done(done), .busy(busy),
        .saturated(saturated), .lock_viol(lock_viol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: ceil(T*f/1e9) per timing, then clamp/subtract/max/saturate.
    function automatic void exp_result(input logic [1:0] m, input logic [31:0] f,
                                       output logic [7:0] n, output logic [15:0] tc,
                                       output logic sat);
        longint unsigned tconv[4] = '{2500, 1200, 660, 2500};
        longint unsigned tcyc[4]  = '{4000, 2000, 1000, 4000};
        longint unsigned q1, q2, conv, cyc, r;
        q1   = (tconv[m] * longint'(f) + 64'd999_999_999) / 64'd1_000_000_000;
        q2   = (tcyc[m] * longint'(f) + 64'd999_999_999) / 64'd1_000_000_000;
        conv = (q1 < 3) ? 3 : q1;
        cyc  = (q2 > 16) ? q2 - 16 : 0;
        r    = (conv > cyc) ? conv : cyc;
        n    = (r > 255) ? 8'd255 : 8'(r);
        sat  = (r > 255);
        tc   = (conv > 65535) ? 16'hFFFF : 16'(conv);
    endfunction

    // Model state: whether a request is active, and edges elapsed since the starting edge.
    logic        chk_en = 1'b0;
    logic        m_run = 1'b0, m_done = 1'b0, m_lock = 1'b0, m_sat = 1'b0;
    logic [7:0]  m_n = '0;
    logic [15:0] m_tc = '0;
    logic [31:0] m_f = '0;
    logic [1:0]  m_m = '0;
    int          m_el = 0;

    always @(posedge clk) begin
        if (!resetn) begin
            chk_en = 1'b1;
            m_run = 0; m_el = 0; m_done = 0; m_lock = 0; m_sat = 0;
            m_n = '0; m_tc = '0; m_f = '0; m_m = '0;
        end else if (!m_run) begin
            if (calc) begin
                m_run = 1; m_el = 0; m_f = spi_clk_freq_hz; m_m = model_sel;
                m_lock = 0; m_sat = 0; m_done = 0;
            end
        end else if (spi_clk_freq_hz != m_f || model_sel != m_m) begin
            m_lock = 1; m_done = 0; m_run = 0;
        end else if (!calc) begin
            m_done = 0; m_run = 0;
        end else begin
            if (m_el < 1000) m_el++;
            if (m_el == 132) begin
                exp_result(m_m, m_f, m_n, m_tc, m_sat);
                m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic m_busy;
            m_busy = m_run && (m_el < 131);
            check("cycle_outputs",
                  32'({done, busy, saturated, lock_viol, n_cs_high_time, t_conv_cycles}),
                  32'({m_done, m_busy, m_sat, m_lock, m_n, m_tc}));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Counts edges from the next one (k=0 samples calc) until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #2;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_calc(input string name, input logic [1:0] m, input logic [31:0] f,
                            input logic [7:0] en, input logic [15:0] etc, input logic esat);
        int lat;
        model_sel       = m;
        spi_clk_freq_hz = f;
        calc            = 1'b1;
        wait_done(lat);
        check({name, "_latency"}, 32'(lat), 32'd132);
        check({name, "_n_cs"}, 32'(n_cs_high_time), 32'(en));
        check({name, "_t_conv"}, 32'(t_conv_cycles), 32'(etc));
        check({name, "_sat"}, 32'(saturated), 32'(esat));
        calc = 1'b0;
        tick(2);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [31:0] f;
        logic [7:0]  n;
        logic [15:0] tc;
        logic        sat;
    } vec_t;

    initial begin
        int   lat;
        vec_t vecs[5];
        vecs[0] = '{m: 2'd3, f: 32'd50_000_000,    n: 8'd184, tc: 16'd125,   sat: 1'b0};
        vecs[1] = '{m: 2'd1, f: 32'd200_000_000,   n: 8'd255, tc: 16'd240,   sat: 1'b1};
        vecs[2] = '{m: 2'd0, f: 32'd4_000_000_000, n: 8'd255, tc: 16'd10000, sat: 1'b1};
        vecs[3] = '{m: 2'd2, f: 32'd50_000_000,    n: 8'd34,  tc: 16'd33,    sat: 1'b0};
        vecs[4] = '{m: 2'd1, f: 32'd20_000_000,    n: 8'd24,  tc: 16'd24,    sat: 1'b0};

        resetn = 1'b0; calc = 1'b0; spi_clk_freq_hz = '0; model_sel = '0;
        tick(3);
        check("reset_outputs",
              32'({done, busy, saturated, lock_viol, n_cs_high_time, t_conv_cycles}), 32'd0);
        resetn = 1'b1;
        tick(1);

        run_calc("m2_50M",  2'd2, 32'd50_000_000,  8'd34,  16'd33,  1'b0);
        run_calc("m0_100M", 2'd0, 32'd100_000_000, 8'd255, 16'd250, 1'b1);
        run_calc("m2_10M",  2'd2, 32'd10_000_000,  8'd7,   16'd7,   1'b0);
        run_calc("m1_1M",   2'd1, 32'd1_000_000,   8'd3,   16'd3,   1'b0);
        run_calc("f0",      2'd0, 32'd0,           8'd3,   16'd3,   1'b0);

        // Frequency change while the first division runs.
        model_sel = 2'd2; spi_clk_freq_hz = 32'd50_000_000; calc = 1'b1;
        tick(1);
        tick(39);
        spi_clk_freq_hz = 32'd20_000_000;
        tick(1);
        check("freq_abort_lock", 32'(lock_viol), 32'd1);
        check("freq_abort_done", 32'(done), 32'd0);
        check("freq_abort_keep_n", 32'(n_cs_high_time), 32'd3);
        wait_done(lat);
        check("freq_restart_latency", 32'(lat), 32'd132);
        check("freq_restart_lock", 32'(lock_viol), 32'd0);
        check("freq_restart_n", 32'(n_cs_high_time), 32'd14);

        // Model change while holding a completed result.
        model_sel = 2'd1;
        tick(1);
        check("model_abort_lock", 32'(lock_viol), 32'd1);
        check("model_abort_done", 32'(done), 32'd0);
        check("model_abort_keep_n", 32'(n_cs_high_time), 32'd14);
        wait_done(lat);
        check("model_restart_latency", 32'(lat), 32'd132);
        check("model_restart_n", 32'(n_cs_high_time), 32'd24);
        calc = 1'b0;
        tick(2);

        // calc dropped at edge 100, then re-raised.
        model_sel = 2'd0; spi_clk_freq_hz = 32'd10_000_000; calc = 1'b1;
        tick(1);
        tick(99);
        calc = 1'b0;
        tick(1);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_lock", 32'(lock_viol), 32'd0);
        check("drop_keep_n", 32'(n_cs_high_time), 32'd24);
        tick(1);
        calc = 1'b1;
        wait_done(lat);
        check("reraise_latency", 32'(lat), 32'd132);
        check("reraise_n", 32'(n_cs_high_time), 32'd25);
        calc = 1'b0;
        tick(2);

        // Reset mid-calculation.
        model_sel = 2'd2; spi_clk_freq_hz = 32'd50_000_000; calc = 1'b1;
        tick(1);
        tick(69);
        resetn = 1'b0;
        tick(1);
        check("midreset_outputs",
              32'({done, busy, saturated, lock_viol, n_cs_high_time, t_conv_cycles}), 32'd0);
        resetn = 1'b1; calc = 1'b0;
        tick(2);

        foreach (vecs[i])
            run_calc($sformatf("b2b%0d", i), vecs[i].m, vecs[i].f, vecs[i].n, vecs[i].tc, vecs[i].sat);

        tick(3);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
